conv_window_gen: RTL and testbench

//  Consumes the row stream read out of the ping-pong frame buffer. Each row is ROW_PIX pixels, pixel 0 in the MSBs.

---
 rtl/conv_window_gen_pkg.sv | 30 +++
 rtl/conv_window_gen_if.sv | 38 +++
 rtl/conv_window_gen_row_tap3.sv | 30 +++
 rtl/conv_window_gen.sv | 152 +++++++++++++++
 tb/tb_conv_window_gen.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_window_gen_pkg.sv
// ============================================================================
//  Module   : conv_pkg
//  Purpose  : Shared geometry, widths and state encoding for conv_window_gen.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package conv_pkg;

    localparam int PIX_W    = 8;
    localparam int ROW_PIX  = 34;
    localparam int ROWS     = 34;
    localparam int K        = 3;
    localparam int COL_W    = $clog2(ROW_PIX);
    localparam int ROW_W    = $clog2(ROWS);
    localparam int ROW_BITS = ROW_PIX * PIX_W;
    localparam int WIN_BITS = K * K * PIX_W;
    localparam int LAST_COL = ROW_PIX - K;

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        SLIDE = 1'b1
    } state_e;

    typedef logic [COL_W-1:0] col_t;
    typedef logic [ROW_W-1:0] row_t;

endpackage

`default_nettype wire

// File: rtl/conv_window_gen_if.sv
// ============================================================================
//  Module   : conv_window_gen_if
//  Purpose  : Row-stream input and 3x3 window output handshake bundle.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface conv_window_gen_if;
    import conv_pkg::*;

    logic                row_valid;
    logic                row_ready;
    logic [ROW_BITS-1:0] row_data;
    logic                row_last;

    logic                win_valid;
    logic                win_ready;
    logic [WIN_BITS-1:0] win_data;
    col_t                win_col;
    row_t                win_row;
    logic                win_last;
    logic                frame_err;

    // master: the window generator itself
    modport master (
        input  row_valid, row_data, row_last, win_ready,
        output row_ready, win_valid, win_data, win_col, win_row, win_last, frame_err
    );

    // slave: row source and window consumer environment
    modport slave (
        output row_valid, row_data, row_last, win_ready,
        input  row_ready, win_valid, win_data, win_col, win_row, win_last, frame_err
    );

endinterface

`default_nettype wire

// File: rtl/conv_window_gen_row_tap3.sv
// ============================================================================
//  Module   : row_tap3
//  Purpose  : Extracts pixels col, col+1, col+2 (MSB-first) from one row bus.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module row_tap3
    import conv_pkg::*;
(
    input  wire logic [ROW_BITS-1:0]  i_row,
    input  wire logic [COL_W-1:0]     i_col,
    output logic      [K*PIX_W-1:0]   o_pix
);

    localparam int SH_W = COL_W + $clog2(PIX_W) + 1;

    logic [COL_W-1:0] w_cols_right;
    logic [SH_W-1:0]  w_shamt;

    // Pixel 0 sits in the MSBs, so the tap is right-aligned by the pixels to its right.
    always_comb begin
        w_cols_right = COL_W'(LAST_COL) - i_col;
        w_shamt      = SH_W'(w_cols_right) * SH_W'(PIX_W);
        o_pix        = (K*PIX_W)'(i_row >> w_shamt);
    end

endmodule

`default_nettype wire

// File: rtl/conv_window_gen.sv
// ============================================================================
//  Module   : conv_window_gen
//  Purpose  : Holds a 3-row band of the row stream and emits 3x3 windows.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module conv_window_gen
    import conv_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          rst,
    conv_window_gen_if.master  bus
);

    localparam logic [0:0] c_ST_FILL  = FILL;
    localparam logic [0:0] c_ST_SLIDE = SLIDE;
    localparam col_t       c_LAST_COL = COL_W'(LAST_COL);

    logic [0:0]          r_state;
    logic [ROW_BITS-1:0] r_row [K];
    logic [1:0]          r_rows_held;
    col_t                r_col;
    row_t                r_band;
    logic                r_last_seen;

    logic                r_win_valid;
    logic [WIN_BITS-1:0] r_win_data;
    col_t                r_win_col;
    row_t                r_win_row;
    logic                r_win_last;
    logic                r_frame_err;

    logic                w_in_fill;
    logic                w_row_acc;
    logic                w_win_acc;
    logic                w_band_full;
    logic                w_col_adv;
    logic                w_band_done;
    logic                w_load_win;
    logic                w_last_nxt;
    col_t                w_col_nxt;
    logic [ROW_BITS-1:0] w_row_nxt [K];
    logic [WIN_BITS-1:0] w_win_nxt;

    assign w_in_fill     = (r_state == c_ST_FILL);
    assign bus.row_ready = w_in_fill && !rst;
    assign w_row_acc     = bus.row_valid && bus.row_ready;
    assign w_win_acc     = r_win_valid && bus.win_ready;
    assign w_band_full   = w_in_fill && w_row_acc && (r_rows_held == 2'd2);
    assign w_col_adv     = !w_in_fill && w_win_acc && (r_col != c_LAST_COL);
    assign w_band_done   = !w_in_fill && w_win_acc && (r_col == c_LAST_COL);
    assign w_load_win    = w_band_full || w_col_adv;
    assign w_col_nxt     = w_in_fill ? '0 : r_col + COL_W'(1);
    assign w_last_nxt    = w_in_fill ? bus.row_last : r_last_seen;

    // Taps look at the post-accept rows so the first window is ready one cycle after the 3rd row.
    always_comb begin
        for (int i = 0; i < K - 1; i++) begin
            w_row_nxt[i] = w_row_acc ? r_row[i+1] : r_row[i];
        end
        w_row_nxt[K-1] = w_row_acc ? bus.row_data : r_row[K-1];
    end

    for (genvar g = 0; g < K; g++) begin : g_tap
        row_tap3 u_tap (
            .i_row (w_row_nxt[g]),
            .i_col (w_col_nxt),
            .o_pix (w_win_nxt[WIN_BITS-1-g*K*PIX_W -: K*PIX_W])
        );
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < K; i++) begin
            r_row[i] <= w_row_nxt[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_FILL;
            r_rows_held <= 2'd0;
            r_col       <= '0;
            r_band      <= '0;
            r_last_seen <= 1'b0;
            r_win_valid <= 1'b0;
            r_win_data  <= '0;
            r_win_col   <= '0;
            r_win_row   <= '0;
            r_win_last  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;

            if (w_load_win) begin
                r_win_valid <= 1'b1;
                r_win_data  <= w_win_nxt;
                r_win_col   <= w_col_nxt;
                r_win_row   <= r_band;
                r_win_last  <= w_last_nxt && (w_col_nxt == c_LAST_COL);
            end else if (w_band_done) begin
                r_win_valid <= 1'b0;
                r_win_last  <= 1'b0;
            end

            case (r_state)
                c_ST_FILL: begin
                    if (w_row_acc) begin
                        if (r_rows_held == 2'd2) begin
                            r_state     <= c_ST_SLIDE;
                            r_col       <= '0;
                            r_last_seen <= bus.row_last;
                        end else if (bus.row_last) begin
                            // Frame too short for any window: drop it.
                            r_frame_err <= 1'b1;
                            r_rows_held <= 2'd0;
                            r_band      <= '0;
                        end else begin
                            r_rows_held <= r_rows_held + 2'd1;
                        end
                    end
                end
                default: begin
                    if (w_win_acc) begin
                        if (r_col != c_LAST_COL) begin
                            r_col <= w_col_nxt;
                        end else begin
                            r_state <= c_ST_FILL;
                            if (r_last_seen) begin
                                r_band      <= '0;
                                r_rows_held <= 2'd0;
                                r_last_seen <= 1'b0;
                            end else begin
                                r_band <= r_band + ROW_W'(1);
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign bus.win_valid = r_win_valid;
    assign bus.win_data  = r_win_data;
    assign bus.win_col   = r_win_col;
    assign bus.win_row   = r_win_row;
    assign bus.win_last  = r_win_last;
    assign bus.frame_err = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_conv_window_gen.sv
// ============================================================================
//  Module   : tb_conv_window_gen
//  Purpose  : Self-checking bench for conv_window_gen against a frame-level model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_conv_window_gen;
    import conv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_window_gen_if u_if ();

    conv_window_gen u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.master)
    );

    typedef struct packed {
        logic [WIN_BITS-1:0] data;
        col_t                col;
        row_t                row;
        logic                last;
    } win_t;

    win_t exp_q[$];
    int   rise_q[$];
    int   n_tests      = 0;
    int   n_fail       = 0;
    int   cyc          = 0;
    int   err_seen     = 0;
    int   win_seen     = 0;
    int   last_acc_cyc = -1;
    int   b2b_gap      = -1;
    bit   chk_en       = 1'b1;
    bit   rand_ready   = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [PIX_W-1:0] pix(input int seed, input int r, input int c);
        return PIX_W'((r * ROW_PIX + c + seed) % 256);
    endfunction

    function automatic logic [ROW_BITS-1:0] make_row(input int seed, input int r);
        logic [ROW_BITS-1:0] d;
        d = '0;
        for (int c = 0; c < ROW_PIX; c++) d[ROW_BITS-1-PIX_W*c -: PIX_W] = pix(seed, r, c);
        return d;
    endfunction

    // Every window of a frame: bands 0..nrows-3, columns 0..ROW_PIX-3.
    function automatic void push_frame_model(input int seed, input int nrows);
        for (int b = 0; b <= nrows - K; b++) begin
            for (int c = 0; c <= ROW_PIX - K; c++) begin
                win_t w;
                w.data = '0;
                for (int i = 0; i < K; i++)
                    for (int j = 0; j < K; j++)
                        w.data[WIN_BITS-1-PIX_W*(K*i+j) -: PIX_W] = pix(seed, b + i, c + j);
                w.col  = COL_W'(c);
                w.row  = ROW_W'(b);
                w.last = (b == nrows - K) && (c == ROW_PIX - K);
                exp_q.push_back(w);
            end
        end
    endfunction

    // ---------------- monitor / compare ----------------
    win_t cur_w, prev_w, e_w;
    bit   prev_stall = 1'b0, prev_valid = 1'b0, prev_row_acc = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            chk("row_ready_in_rst", u_if.row_ready, 0);
            prev_stall = 1'b0; prev_valid = 1'b0; prev_row_acc = 1'b0;
        end else begin
            cur_w = '{data: u_if.win_data, col: u_if.win_col, row: u_if.win_row, last: u_if.win_last};
            if (u_if.win_valid) chk("row_ready_in_slide", u_if.row_ready, 0);
            if (prev_stall) begin
                chk("stall_valid", u_if.win_valid, 1);
                chk("stall_hold", cur_w, prev_w);
            end
            if (u_if.win_valid && !prev_valid) begin
                chk("rise_after_row", prev_row_acc, 1);
                chk("rise_col0", u_if.win_col, 0);
                rise_q.push_back(cyc);
                if (u_if.win_row == 0 && last_acc_cyc >= 0) begin
                    b2b_gap = cyc - last_acc_cyc;
                    last_acc_cyc = -1;
                end
            end
            if (u_if.frame_err) err_seen++;
            if (u_if.win_valid && u_if.win_ready) begin
                win_seen++;
                if (u_if.win_last) last_acc_cyc = cyc;
                if (chk_en) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_window", 1, 0);
                    end else begin
                        e_w = exp_q.pop_front();
                        chk("win_data", cur_w.data, e_w.data);
                        chk("win_col",  cur_w.col,  e_w.col);
                        chk("win_row",  cur_w.row,  e_w.row);
                        chk("win_last", cur_w.last, e_w.last);
                    end
                end
            end
            prev_stall   = u_if.win_valid && !u_if.win_ready;
            prev_w       = cur_w;
            prev_valid   = u_if.win_valid;
            prev_row_acc = u_if.row_valid && u_if.row_ready;
        end
    end

    // ---------------- window consumer ----------------
    initial begin
        u_if.win_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            u_if.win_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- row source ----------------
    task automatic send_row(input logic [ROW_BITS-1:0] d, input logic last);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        u_if.row_valid = 1'b1;
        u_if.row_data  = d;
        u_if.row_last  = last;
        while (!acc) begin
            @(negedge clk);
            acc = u_if.row_ready;
            @(posedge clk);
            #1;
            n++;
            if (!acc && n > 2000) begin
                chk("row_accept_timeout", 0, 1);
                acc = 1'b1;
            end
        end
    endtask

    task automatic send_frame(input int seed, input int nrows, input bit keep_valid);
        if (nrows >= K) push_frame_model(seed, nrows);
        for (int r = 0; r < nrows; r++) send_row(make_row(seed, r), 1'(r == nrows - 1));
        if (!keep_valid) u_if.row_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    logic [WIN_BITS-1:0] lit;
    int w0, e0, bad, n;

    initial begin
        u_if.row_valid = 1'b0;
        u_if.row_data  = '0;
        u_if.row_last  = 1'b0;
        rst = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_win_valid", u_if.win_valid, 0);
        chk("rst_win_data",  u_if.win_data,  0);
        chk("rst_win_col",   u_if.win_col,   0);
        chk("rst_win_row",   u_if.win_row,   0);
        chk("rst_win_last",  u_if.win_last,  0);
        chk("rst_frame_err", u_if.frame_err, 0);
        chk("rst_row_ready", u_if.row_ready, 1);
        @(posedge clk); #1;

        // Test 1 (+6): full frame, win_ready=1; pin the model with literals.
        rise_q.delete();
        w0 = win_seen;
        push_frame_model(0, ROWS);
        chk("model_count", exp_q.size(), 1024);
        lit = {8'd0, 8'd1, 8'd2, 8'd34, 8'd35, 8'd36, 8'd68, 8'd69, 8'd70};
        chk("model_first", exp_q[0].data, lit);
        lit = {8'd61, 8'd62, 8'd63, 8'd95, 8'd96, 8'd97, 8'd129, 8'd130, 8'd131};
        chk("model_last_data", exp_q[1023].data, lit);
        chk("model_last_pos", {exp_q[1023].row, exp_q[1023].col, exp_q[1023].last}, {6'd31, 6'd31, 1'b1});
        chk("model_not_last", exp_q[1022].last, 0);
        exp_q.delete();
        send_frame(0, ROWS, 1'b0);
        wait_drain();
        chk("t1_win_count", win_seen - w0, 1024);
        chk("t6_band_count", rise_q.size(), 32);
        bad = 0;
        for (int i = 1; i < rise_q.size(); i++) if (rise_q[i] - rise_q[i-1] != 33) bad++;
        chk("t6_band_period", bad, 0);

        // Test 2: same frame with random back-pressure.
        rand_ready = 1'b1;
        w0 = win_seen;
        send_frame(0, ROWS, 1'b0);
        wait_drain();
        chk("t2_win_count", win_seen - w0, 1024);
        rand_ready = 1'b0;

        // Test 3: 2-row frame is dropped, next frame unaffected.
        e0 = err_seen;
        w0 = win_seen;
        send_frame(0, 2, 1'b0);
        wait_cycles(10);
        chk("t3_frame_err", err_seen - e0, 1);
        chk("t3_no_windows", win_seen - w0, 0);
        send_frame(0, ROWS, 1'b0);
        wait_drain();
        chk("t3_win_count", win_seen - w0, 1024);
        chk("t3_no_more_err", err_seen - e0, 1);

        // Test 4: reset mid-frame at band 5, column 10.
        chk_en = 1'b0;
        for (int r = 0; r < 8; r++) send_row(make_row(11, r), 1'b0);
        u_if.row_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(u_if.win_valid && u_if.win_row == 5 && u_if.win_col == 9) && n < 500);
        chk("t4_reach_band5", n < 500, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t4_valid_after_rst", u_if.win_valid, 0);
        chk("t4_ready_after_rst", u_if.row_ready, 1);
        exp_q.delete();
        chk_en = 1'b1;
        @(posedge clk); #1;
        w0 = win_seen;
        send_frame(7, ROWS, 1'b0);
        wait_drain();
        chk("t4_win_count", win_seen - w0, 1024);

        // Test 5: back-to-back frames with row_valid held high.
        last_acc_cyc = -1;
        b2b_gap = -1;
        w0 = win_seen;
        send_frame(3, ROWS, 1'b1);
        send_frame(5, ROWS, 1'b0);
        wait_drain();
        chk("t5_gap", b2b_gap, 4);
        chk("t5_win_count", win_seen - w0, 2048);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1);
    end

endmodule

`default_nettype wire
